// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter types and constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;
    localparam logic LINE_IDLE    = 1'b1;
    localparam int   MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// rtl/uart_tx_bit_timer.sv - per-bit clock counter and frame bit counter for uart_tx
module tx_bit_timer #(
    parameter int prescalar_width = 6,
    parameter int bit_count_width = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic [prescalar_width-1:0] ps,
    output logic                       bit_tick,
    output logic                       bit_pre_tick,
    output logic [bit_count_width-1:0] bit_cnt
);

    localparam logic [prescalar_width-1:0] PS_ONE = prescalar_width'(1);
    localparam logic [prescalar_width-1:0] PS_TWO = prescalar_width'(2);
    localparam logic [bit_count_width-1:0] BC_ONE = bit_count_width'(1);

    logic [prescalar_width-1:0] clk_cnt;

    // bit_tick marks the last clock of a bit; bit_pre_tick the clock before it
    assign bit_tick     = run && (clk_cnt == (ps - PS_ONE));
    assign bit_pre_tick = run && (clk_cnt == (ps - PS_TWO));

    // Count clocks within a bit and bits within the frame; both held at zero while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else if (!run) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else if (bit_tick) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + BC_ONE;
        end else begin
            clk_cnt <= clk_cnt + PS_ONE;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame transmitter with optional parity and per-frame prescale
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int prescalar_width = 6,
    parameter int bit_count_width = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [DATA_WIDTH-1:0]      P_DATA,
    input  logic                       DATA_VALID,
    input  logic                       PAR_EN,
    input  logic                       PAR_TYP,
    input  logic [prescalar_width-1:0] Prescale,
    output logic                       TX_OUT,
    output logic                       Busy,
    output logic                       tx_done
);

    localparam logic [prescalar_width-1:0] MIN_PS    = prescalar_width'(MIN_PRESCALE);
    localparam logic [bit_count_width-1:0] LAST_DATA = bit_count_width'(DATA_WIDTH);

    tx_state_e                  state;
    logic [DATA_WIDTH-1:0]      shift_q;
    logic                       par_en_q;
    logic                       par_q;
    logic [prescalar_width-1:0] ps_q;

    logic                       bit_tick;
    logic                       bit_pre_tick;
    logic [bit_count_width-1:0] bit_cnt;

    // bit_cnt counts frame bits: 0 = start, 1..DATA_WIDTH = data, then parity/stop
    tx_bit_timer #(
        .prescalar_width(prescalar_width),
        .bit_count_width(bit_count_width)
    ) u_timer (
        .clk          (CLK),
        .rst_n        (RST),
        .run          (Busy),
        .ps           (ps_q),
        .bit_tick     (bit_tick),
        .bit_pre_tick (bit_pre_tick),
        .bit_cnt      (bit_cnt)
    );

    // Frame FSM: latches the request, shifts data LSB first and drives the registered line
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            TX_OUT   <= LINE_IDLE;
            Busy     <= 1'b0;
            tx_done  <= 1'b0;
            shift_q  <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            ps_q     <= MIN_PS;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (DATA_VALID) begin
                        shift_q  <= P_DATA;
                        par_en_q <= PAR_EN;
                        par_q    <= (PAR_TYP == PAR_EVEN) ? ^P_DATA : ~^P_DATA;
                        ps_q     <= (Prescale < MIN_PS) ? MIN_PS : Prescale;
                        state    <= START;
                        TX_OUT   <= 1'b0;
                        Busy     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state   <= DATA;
                        TX_OUT  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            if (par_en_q) begin
                                state  <= PARITY;
                                TX_OUT <= par_q;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= LINE_IDLE;
                            end
                        end else begin
                            TX_OUT  <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state  <= STOP;
                        TX_OUT <= LINE_IDLE;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        state  <= IDLE;
                        Busy   <= 1'b0;
                        TX_OUT <= LINE_IDLE;
                    end else if (bit_pre_tick) begin
                        tx_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    Busy   <= 1'b0;
                    TX_OUT <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level line model
module tb_uart_tx;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_typ;
        logic [5:0] ps;
    } cfg_t;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       Busy;
    logic       tx_done;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy),
        .tx_done    (tx_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cfg_t mk(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        cfg_t c;
        c.data = d; c.par_en = pe; c.par_typ = pt; c.ps = ps;
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        return mk(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 20)));
    endfunction

    function automatic int eff_ps(input cfg_t c);
        return (c.ps < 4) ? 4 : int'(c.ps);
    endfunction

    function automatic int frame_len(input cfg_t c);
        return (10 + int'(c.par_en)) * eff_ps(c);
    endfunction

    // Expected line level for frame bit b: start, 8 data LSB first, optional parity, stop
    function automatic logic exp_bit(input cfg_t c, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return c.data[b-1];
        if (c.par_en && b == 9) return c.par_typ ? ~^c.data : ^c.data;
        return 1'b1;
    endfunction

    task automatic drive(input cfg_t c, input logic valid);
        P_DATA     = c.data;
        PAR_EN     = c.par_en;
        PAR_TYP    = c.par_typ;
        Prescale   = c.ps;
        DATA_VALID = valid;
    endtask

    // Called just before the accept edge; checks ncyc cycles of the frame (0 = whole frame)
    // and presents the next request (held or not) during the first frame cycle
    task automatic expect_frame(input cfg_t c, input cfg_t nxt, input logic hold, input int ncyc);
        int eps, len, busy_n, done_n;
        logic [7:0] rx;
        eps = eff_ps(c);
        len = frame_len(c);
        busy_n = 0; done_n = 0; rx = '0;
        if (ncyc == 0) ncyc = len;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge CLK);
            check_value("line", TX_OUT, exp_bit(c, i / eps));
            check_value("done", tx_done, (i == len - 1) ? 1 : 0);
            if (Busy) busy_n++;
            if ((i % eps) == eps / 2 && (i / eps) >= 1 && (i / eps) <= 8) rx[i/eps-1] = TX_OUT;
            if (i == 0) drive(nxt, hold);
        end
        if (ncyc == len) begin
            check_value("busy_len", busy_n, len);
            check_value("rx_data", rx, c.data);
        end else begin
            check_value("busy_part", busy_n, ncyc);
        end
    endtask

    task automatic idle_check();
        @(negedge CLK);
        check_value("idle_line", TX_OUT, 1);
        check_value("idle_busy", Busy, 0);
        check_value("idle_done", tx_done, 0);
    endtask

    cfg_t zc, c, nx;
    logic hold;

    initial begin
        zc = mk(8'h00, 1'b0, 1'b0, 6'd8);
        RST = 1'b0;
        drive(zc, 1'b0);
        repeat (2) @(negedge CLK);
        check_value("rst_line", TX_OUT, 1);
        check_value("rst_busy", Busy, 0);
        check_value("rst_done", tx_done, 0);
        RST = 1'b1;
        idle_check();

        // A5 even parity, 55 held valid during the frame then sent after an idle cycle
        c  = mk(8'hA5, 1'b1, 1'b0, 6'd8);
        nx = mk(8'h55, 1'b0, 1'b1, 6'd8);
        drive(c, 1'b1);
        expect_frame(c, nx, 1'b1, 0);
        idle_check();
        expect_frame(nx, zc, 1'b0, 0);
        idle_check();

        // 01 with even then odd parity
        c  = mk(8'h01, 1'b1, 1'b0, 6'd8);
        nx = mk(8'h01, 1'b1, 1'b1, 6'd8);
        drive(c, 1'b1);
        expect_frame(c, nx, 1'b1, 0);
        idle_check();
        expect_frame(nx, zc, 1'b0, 0);
        idle_check();

        // FF, no parity, prescale 16
        c = mk(8'hFF, 1'b0, 1'b0, 6'd16);
        drive(c, 1'b1);
        expect_frame(c, zc, 1'b0, 0);
        idle_check();

        // 3C then C3 back to back at prescale 32
        c  = mk(8'h3C, 1'b0, 1'b0, 6'd32);
        nx = mk(8'hC3, 1'b0, 1'b0, 6'd32);
        drive(c, 1'b1);
        expect_frame(c, nx, 1'b1, 0);
        idle_check();
        expect_frame(nx, zc, 1'b0, 0);
        idle_check();

        // Random frames, random back-to-back holds and idle gaps
        c = rand_cfg();
        drive(c, 1'b1);
        for (int f = 0; f < 30; f++) begin
            nx   = rand_cfg();
            hold = 1'($urandom);
            expect_frame(c, nx, hold, 0);
            idle_check();
            if (!hold) begin
                repeat ($urandom_range(0, 3)) idle_check();
                drive(nx, 1'b1);
            end
            c = nx;
        end
        expect_frame(c, zc, 1'b0, 0);
        idle_check();

        // Reset during data bit 3 with prescale 2 (clamped to 4)
        c = mk(8'hB6, 1'b1, 1'b1, 6'd2);
        drive(c, 1'b1);
        expect_frame(c, zc, 1'b0, 18);
        #2 RST = 1'b0;
        #1;
        check_value("abort_line", TX_OUT, 1);
        check_value("abort_busy", Busy, 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (30) idle_check();
        c = mk(8'h6D, 1'b1, 1'b0, 6'd3);
        drive(c, 1'b1);
        expect_frame(c, zc, 1'b0, 0);
        idle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
